// File: rtl/sysid_check_master.sv
// Avalon-MM read master: reads the sysid ID (addr 0) and timestamp (addr 1),
// latches both and reports pass/fail against build-time expected values.
module sysid_check_master #(
  parameter logic [31:0] EXPECTED_ID = 32'd11141120,
  parameter logic [31:0] EXPECTED_TS = 32'd1603659914,
  parameter bit          CHECK_TS    = 1'b1,
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, EVAL} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_arm;
  logic        r_addr;
  logic        r_read;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic        r_tmo_err;
  logic [31:0] r_id;
  logic [31:0] r_ts;
  logic [15:0] r_cnt;

  logic        w_go;
  logic        w_accept;
  logic        w_expire;
  logic        w_pass;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // The stall that would bring the counter to TIMEOUT is the one that aborts;
  // an accept in that same cycle takes priority.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = start | r_arm;
    w_accept    = r_read & ~waitrequest;
    w_expire    = r_read & waitrequest & (r_cnt == TMO_LAST);
    w_pass      = (r_id == EXPECTED_ID) && (!CHECK_TS || (readdata == EXPECTED_TS));
    case (r_state)
      IDLE:  if (w_go) w_state_nxt = RD_ID;
      RD_ID: begin
        if (w_accept)      w_state_nxt = RD_TS;
        else if (w_expire) w_state_nxt = IDLE;
      end
      RD_TS: begin
        if (w_accept)      w_state_nxt = EVAL;
        else if (w_expire) w_state_nxt = IDLE;
      end
      EVAL:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_arm     <= AUTO_START;
      r_addr    <= 1'b0;
      r_read    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_tmo_err <= 1'b0;
      r_id      <= 32'd0;
      r_ts      <= 32'd0;
      r_cnt     <= 16'd0;
    end else begin
      r_arm  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_busy    <= 1'b1;
            r_read    <= 1'b1;
            r_addr    <= 1'b0;
            r_pass    <= 1'b0;
            r_tmo_err <= 1'b0;
            r_cnt     <= 16'd0;
          end
        end
        RD_ID, RD_TS: begin
          if (w_accept) begin
            r_cnt <= 16'd0;
            if (r_state == RD_ID) begin
              r_id   <= readdata;
              r_addr <= 1'b1;
            end else begin
              // pass is computed from live readdata so it is valid in EVAL
              r_ts   <= readdata;
              r_read <= 1'b0;
              r_pass <= w_pass;
              r_done <= 1'b1;
            end
          end else if (w_expire) begin
            r_read    <= 1'b0;
            r_tmo_err <= 1'b1;
            r_pass    <= 1'b0;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_cnt     <= 16'd0;
          end else if (waitrequest) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        EVAL:    r_busy <= 1'b0;
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign address     = r_addr;
  assign read        = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout_err = r_tmo_err;
  assign id_value    = r_id;
  assign ts_value    = r_ts;

endmodule

// File: doc/sysid_check_master.md
Name: sysid_check_master

Overview:
- Avalon-MM read master that drives a system-ID slave's control interface.
- Reads the ID word (address 0) and the timestamp word (address 1), latches both and compares them against build-time expected values.
- Reports pass/fail to boot/status logic, e.g. to gate CPU release or drive a LED.
- Sits in the same clock domain as the system-ID slave.

Parameters:
- EXPECTED_ID, 32'd11141120, value required at address 0
- EXPECTED_TS, 32'd1603659914, value required at address 1
- CHECK_TS, 1, 1 = timestamp mismatch fails the check; 0 = timestamp is read and latched but ignored for pass/fail
- TIMEOUT, 255, maximum cycles a single read may stall on waitrequest; legal range 1..65535
- AUTO_START, 1, 1 = one check starts automatically on the first cycle after reset deasserts

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to run a check; ignored while busy=1
- address  out  1  Avalon address to the sysid slave (0 = ID, 1 = timestamp)
- read  out  1  Avalon read strobe
- waitrequest  in  1  slave stall; tie 0 for a zero-wait slave
- readdata  in  32  slave read data, sampled when read=1 and waitrequest=0
- busy  out  1  check in progress
- done  out  1  one-cycle pulse when a check finishes, whether pass, fail or timeout
- pass  out  1  sticky result of the last completed check
- timeout_err  out  1  sticky: the last check aborted on timeout
- id_value  out  32  latched address-0 data
- ts_value  out  32  latched address-1 data

Behaviour:
- Reset (async assert, sync release): state IDLE; address=0, read=0, busy=0, done=0, pass=0, timeout_err=0, id_value=0, ts_value=0, timeout counter=0.
- States: IDLE, RD_ID, RD_TS, EVAL.
- IDLE:
  - Goes to RD_ID on a start pulse, or on the first post-reset cycle when AUTO_START=1.
  - On entering RD_ID (registered): busy=1, pass=0, timeout_err=0.
- RD_ID:
  - Drives read=1, address=0.
  - address and read must be held stable while waitrequest=1.
  - On read & !waitrequest: id_value <= readdata, counter cleared, go to RD_TS.
  - read stays high into RD_TS, giving back-to-back reads; a read is never deasserted without being accepted unless it times out.
- RD_TS: same handshake at address=1; on accept, ts_value <= readdata and go to EVAL with read=0.
- EVAL:
  - Takes one cycle.
  - pass <= (id_value==EXPECTED_ID) && (!CHECK_TS || ts_value==EXPECTED_TS).
  - Also done=1 for that cycle and busy cleared, then return to IDLE.
- Timeout:
  - The counter increments each cycle read=1 && waitrequest=1 in RD_ID/RD_TS.
  - When the counter reaches TIMEOUT with waitrequest still 1: read<=0, timeout_err<=1, pass<=0, done pulses, busy<=0, go to IDLE.
  - Latched values not yet captured keep their prior contents.
  - If waitrequest drops on the same cycle the counter reaches TIMEOUT, the accept wins and no timeout occurs.
- Latency with waitrequest=0: start sampled in cycle N; read at address 0 in cycle N+1, address 1 in N+2; done and pass valid in N+3. busy high in N+1..N+3 and low from N+4.
- A start pulse arriving while busy=1, including in the same cycle as done, is dropped (not queued).
- Reset asserted mid-check aborts immediately: read drops asynchronously and all outputs return to reset values. AUTO_START re-arms on release.
- pass and timeout_err hold until the next check begins.

Test Plan:
- Zero-wait slave returning 11141120 / 1603659914, AUTO_START=1 → reads at addr 0 then addr 1 on consecutive cycles; done in the 3rd cycle after reset release; pass=1, timeout_err=0, id_value=32'h00AA0000.
- Slave returns ID 0x00AA0001 → pass=0, done pulses, timeout_err=0. Repeat with CHECK_TS=0 and a wrong timestamp only → pass=1.
- waitrequest held high for 5 cycles on address 1 → address/read stable throughout, ts_value captured on the 6th cycle, pass=1, busy high for exactly 8 cycles.
- TIMEOUT=4, waitrequest stuck high → read deasserts after 4 stalled cycles; timeout_err=1, pass=0, done one pulse. Separately, release waitrequest on the 4th stalled cycle → no timeout.
- start pulses in IDLE, mid-RD_TS and on the done cycle → exactly one check runs per accepted start; mid-check pulses are ignored.
- Assert reset during RD_TS with waitrequest high → read=0 immediately and all outputs zero. After release with AUTO_START=1, a full check completes with pass=1.
